ads8689_spi_frame: RTL and testbench

- SPI frame engine for the ADS8689 ADC channel.
- Sits directly downstream of the register/command sequencer that drives wr_trig, rd_trig, rw_len and wr_data.
- Converts each trigger into one chip-select-framed SPI transfer (SPI mode 0, MSB first) and captures the SDO word returned in the same frame.
- Returns frame_done to the upstream control FSM so it can advance its wr_cnt.

---
 rtl/ads8689_spi_frame.sv | 176 +++++++++++++++++
 tb/tb_ads8689_spi_frame.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ads8689_spi_frame.sv
// SPI frame engine for the ADS8689: one cs_n-framed mode-0 transfer per trigger,
// MSB first, with the SDO word captured right-justified in the same frame.
module ads8689_spi_frame #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned CS_SETUP = 2,
    parameter int unsigned CS_HOLD  = 2,
    parameter int unsigned CS_IDLE  = 100
) (
    input  logic        clk_sys,
    input  logic        rst_sys_n,
    input  logic        wr_trig,
    input  logic        rd_trig,
    input  logic [5:0]  rw_len,
    input  logic [31:0] wr_data,
    input  logic        spi_sdo,
    output logic        spi_cs_n,
    output logic        spi_sclk,
    output logic        spi_sdi,
    output logic [31:0] rd_data,
    output logic        rd_vld,
    output logic        frame_done,
    output logic        busy
);

    localparam int unsigned CNT_W  = 11;
    localparam int unsigned LEN_W  = 6;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [LEN_W-1:0]    bit_q, bit_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic                is_rd_q, is_rd_d;
    logic [DATA_W-1:0]   tx_q, tx_d;
    logic [DATA_W-1:0]   rx_q, rx_d;
    logic                cs_n_q, cs_n_d;
    logic                sclk_q, sclk_d;
    logic                sdi_q, sdi_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                rd_vld_q, rd_vld_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic                last_bit_c;

    // Phase counters restart at 1 on each transition, so "cnt == X" marks X cycles elapsed
    assign last_bit_c = (bit_q == len_q - LEN_W'(1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        bit_d     = bit_q;
        len_d     = len_q;
        is_rd_d   = is_rd_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        cs_n_d    = cs_n_q;
        sclk_d    = sclk_q;
        sdi_d     = sdi_q;
        rd_data_d = rd_data_q;
        rd_vld_d  = 1'b0;
        done_d    = 1'b0;
        busy_d    = busy_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (wr_trig || rd_trig) begin
                    state_d = SETUP;
                    cnt_d   = CNT_W'(1);
                    bit_d   = '0;
                    len_d   = (rw_len == '0 || rw_len > LEN_W'(DATA_W)) ? LEN_W'(DATA_W) : rw_len;
                    is_rd_d = rd_trig;
                    tx_d    = wr_data;
                    rx_d    = '0;
                    cs_n_d  = 1'b0;
                    sdi_d   = wr_data[DATA_W-1];
                    busy_d  = 1'b1;
                end
            end
            SETUP: begin
                if (cnt_q == CNT_W'(CS_SETUP)) begin
                    state_d = SHIFT;
                    cnt_d   = CNT_W'(1);
                    sclk_d  = 1'b1;
                    rx_d    = {rx_q[DATA_W-2:0], spi_sdo};
                end
            end
            SHIFT: begin
                if (cnt_q == CNT_W'(CLK_DIV)) begin
                    sclk_d = 1'b0;
                    if (last_bit_c) begin
                        sdi_d = 1'b0;
                    end else begin
                        sdi_d = tx_q[DATA_W-2];
                        tx_d  = {tx_q[DATA_W-2:0], 1'b0};
                    end
                end else if (cnt_q == CNT_W'(2 * CLK_DIV)) begin
                    cnt_d = CNT_W'(1);
                    if (last_bit_c) begin
                        state_d = HOLD;
                    end else begin
                        sclk_d = 1'b1;
                        rx_d   = {rx_q[DATA_W-2:0], spi_sdo};
                        bit_d  = bit_q + LEN_W'(1);
                    end
                end
            end
            HOLD: begin
                if (cnt_q == CNT_W'(CS_HOLD)) begin
                    state_d   = GAP;
                    cnt_d     = CNT_W'(1);
                    cs_n_d    = 1'b1;
                    rd_data_d = rx_q;
                    done_d    = 1'b1;
                    rd_vld_d  = is_rd_q;
                end
            end
            GAP: begin
                if (cnt_q == CNT_W'(CS_IDLE)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            len_q     <= '0;
            is_rd_q   <= 1'b0;
            tx_q      <= '0;
            rx_q      <= '0;
            cs_n_q    <= 1'b1;
            sclk_q    <= 1'b0;
            sdi_q     <= 1'b0;
            rd_data_q <= '0;
            rd_vld_q  <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            len_q     <= len_d;
            is_rd_q   <= is_rd_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            cs_n_q    <= cs_n_d;
            sclk_q    <= sclk_d;
            sdi_q     <= sdi_d;
            rd_data_q <= rd_data_d;
            rd_vld_q  <= rd_vld_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign spi_cs_n   = cs_n_q;
    assign spi_sclk   = sclk_q;
    assign spi_sdi    = sdi_q;
    assign rd_data    = rd_data_q;
    assign rd_vld     = rd_vld_q;
    assign frame_done = done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_ads8689_spi_frame.sv
// Directed bench for ads8689_spi_frame: a table of single frames plus
// back-to-back level-trigger and mid-frame reset sequences, against an ADC model.
module tb_ads8689_spi_frame;

    logic        clk_sys = 1'b0;
    logic        rst_sys_n;
    logic        wr_trig, rd_trig;
    logic [5:0]  rw_len;
    logic [31:0] wr_data;
    logic        spi_sdo;
    logic        spi_cs_n, spi_sclk, spi_sdi;
    logic [31:0] rd_data;
    logic        rd_vld, frame_done, busy;

    ads8689_spi_frame dut (
        .clk_sys    (clk_sys),
        .rst_sys_n  (rst_sys_n),
        .wr_trig    (wr_trig),
        .rd_trig    (rd_trig),
        .rw_len     (rw_len),
        .wr_data    (wr_data),
        .spi_sdo    (spi_sdo),
        .spi_cs_n   (spi_cs_n),
        .spi_sclk   (spi_sclk),
        .spi_sdi    (spi_sdi),
        .rd_data    (rd_data),
        .rd_vld     (rd_vld),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #4 clk_sys = ~clk_sys;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [5:0]  len;
        logic [31:0] wdata;
        logic [31:0] adc;
        logic [31:0] exp_sdi;
        int          pulses;
        int          cs_low;
        logic [31:0] exp_rd;
        logic        exp_vld;
    } vec_t;

    vec_t vecs [7];

    int n_cmp = 0;
    int n_err = 0;

    // Monitor state
    int          cs_low_cnt, pulse_cnt, done_cnt, vld_cnt, cs_falls, hi_run, min_gap, max_gap;
    logic [31:0] sdi_cap, rd_at_done;
    logic        vld_at_done;
    logic [31:0] adc_word;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic clear_mon();
        cs_low_cnt  = 0;
        pulse_cnt   = 0;
        done_cnt    = 0;
        vld_cnt     = 0;
        cs_falls    = 0;
        min_gap     = 32'h7fff_ffff;
        max_gap     = 0;
        sdi_cap     = '0;
        rd_at_done  = '0;
        vld_at_done = 1'b0;
    endtask

    // ADC model: first bit valid at cs_n fall, next bit after each sclk fall
    initial begin : adc_model
        logic [31:0] sr;
        logic pcs, psclk;
        sr = '0; pcs = 1'b1; psclk = 1'b0; spi_sdo = 1'b0;
        forever begin
            @(negedge clk_sys);
            if (!spi_cs_n && pcs) sr = adc_word;
            else if (!spi_sclk && psclk) sr = sr << 1;
            spi_sdo = sr[31];
            pcs = spi_cs_n;
            psclk = spi_sclk;
        end
    end

    initial begin : monitor
        logic pcs, psclk;
        pcs = 1'b1; psclk = 1'b0; hi_run = 0;
        clear_mon();
        forever begin
            @(negedge clk_sys);
            if (!spi_cs_n) cs_low_cnt++;
            if (spi_sclk && !psclk) begin
                pulse_cnt++;
                sdi_cap = {sdi_cap[30:0], spi_sdi};
            end
            if (frame_done) begin
                done_cnt++;
                rd_at_done  = rd_data;
                vld_at_done = rd_vld;
            end
            if (rd_vld) vld_cnt++;
            if (!spi_cs_n && pcs) begin
                if (cs_falls > 0) begin
                    if (hi_run < min_gap) min_gap = hi_run;
                    if (hi_run > max_gap) max_gap = hi_run;
                end
                cs_falls++;
                hi_run = 0;
            end
            if (spi_cs_n) hi_run++;
            pcs = spi_cs_n;
            psclk = spi_sclk;
        end
    end

    task automatic run_vec(input int idx, input vec_t v);
        bit ok;
        @(negedge clk_sys);
        clear_mon();
        adc_word = v.adc;
        wr_data  = v.wdata;
        rw_len   = v.len;
        wr_trig  = v.wr;
        rd_trig  = v.rd;
        for (int i = 0; i < 10 && spi_cs_n; i++) @(negedge clk_sys);
        ok = !spi_cs_n;
        wr_trig = 1'b0;
        rd_trig = 1'b0;
        if (!ok) begin
            timeout($sformatf("v%0d_start", idx));
            return;
        end
        for (int i = 0; i < 1000 && done_cnt == 0; i++) @(negedge clk_sys);
        if (done_cnt == 0) timeout($sformatf("v%0d_done", idx));
        for (int i = 0; i < 300 && busy; i++) @(negedge clk_sys);
        if (busy) timeout($sformatf("v%0d_idle", idx));
        check($sformatf("v%0d_sdi", idx),       sdi_cap,    v.exp_sdi);
        check($sformatf("v%0d_pulses", idx),    pulse_cnt,  v.pulses);
        check($sformatf("v%0d_cs_low", idx),    cs_low_cnt, v.cs_low);
        check($sformatf("v%0d_done_cnt", idx),  done_cnt,   1);
        check($sformatf("v%0d_rd_data", idx),   rd_at_done, v.exp_rd);
        check($sformatf("v%0d_vld_at_done", idx), 32'(vld_at_done), 32'(v.exp_vld));
        check($sformatf("v%0d_vld_cnt", idx),   vld_cnt,    v.exp_vld ? 1 : 0);
    endtask

    initial begin
        //                wr    rd    len   wdata         adc           exp_sdi      pls cs   exp_rd        vld
        vecs[0] = '{1'b1, 1'b0, 6'd32, 32'hD0020003, 32'h12345678, 32'hD0020003, 32, 260, 32'h12345678, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 6'd32, 32'h00000000, 32'hA5A51234, 32'h00000000, 32, 260, 32'hA5A51234, 1'b1};
        vecs[2] = '{1'b0, 1'b1, 6'd16, 32'hC8140000, 32'hBEEF0000, 32'h0000C814, 16, 132, 32'h0000BEEF, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 6'd0,  32'h80000001, 32'h0F0F0F0F, 32'h80000001, 32, 260, 32'h0F0F0F0F, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 6'd40, 32'hFFFF0000, 32'h00000001, 32'hFFFF0000, 32, 260, 32'h00000001, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 6'd1,  32'h80000000, 32'h80000000, 32'h00000001,  1,  12, 32'h00000001, 1'b1};
        vecs[6] = '{1'b1, 1'b0, 6'd8,  32'h5A000000, 32'hC3000000, 32'h0000005A,  8,  68, 32'h000000C3, 1'b0};

        rst_sys_n = 1'b0;
        wr_trig = 1'b0; rd_trig = 1'b0; rw_len = '0; wr_data = '0; adc_word = '0;
        repeat (3) @(negedge clk_sys);
        check("rst_cs_n",   32'(spi_cs_n),   32'd1);
        check("rst_sclk",   32'(spi_sclk),   32'd0);
        check("rst_sdi",    32'(spi_sdi),    32'd0);
        check("rst_rd_data", rd_data,        32'd0);
        check("rst_rd_vld", 32'(rd_vld),     32'd0);
        check("rst_done",   32'(frame_done), 32'd0);
        check("rst_busy",   32'(busy),       32'd0);
        rst_sys_n = 1'b1;
        repeat (2) @(negedge clk_sys);

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        repeat (20) @(negedge clk_sys);
        check("rd_data_hold", rd_data, 32'h000000C3);

        // Level trigger held: three frames, gaps of CS_IDLE+1 cycles
        @(negedge clk_sys);
        clear_mon();
        adc_word = 32'h0; wr_data = 32'h5A000000; rw_len = 6'd8; wr_trig = 1'b1;
        for (int i = 0; i < 1500 && done_cnt < 3; i++) @(negedge clk_sys);
        wr_trig = 1'b0;
        if (done_cnt < 3) timeout("b2b_three_frames");
        for (int i = 0; i < 300 && busy; i++) @(negedge clk_sys);
        if (busy) timeout("b2b_idle");
        repeat (150) @(negedge clk_sys);
        check("b2b_done_cnt", done_cnt,  3);
        check("b2b_cs_falls", cs_falls,  3);
        check("b2b_pulses",   pulse_cnt, 24);
        check("b2b_min_gap",  min_gap,   101);
        check("b2b_max_gap",  max_gap,   101);
        check("b2b_vld_cnt",  vld_cnt,   0);

        // Reset during SHIFT after bit 10
        @(negedge clk_sys);
        clear_mon();
        adc_word = 32'hA5A51234; wr_data = 32'h0; rw_len = 6'd32; rd_trig = 1'b1;
        for (int i = 0; i < 10 && spi_cs_n; i++) @(negedge clk_sys);
        rd_trig = 1'b0;
        for (int i = 0; i < 400 && pulse_cnt < 11; i++) @(negedge clk_sys);
        if (pulse_cnt < 11) timeout("rst_mid_reach_bit10");
        rst_sys_n = 1'b0;
        #1;
        check("rst_mid_cs_n", 32'(spi_cs_n), 32'd1);
        check("rst_mid_sclk", 32'(spi_sclk), 32'd0);
        check("rst_mid_busy", 32'(busy),     32'd0);
        repeat (3) @(negedge clk_sys);
        check("rst_mid_done_cnt", done_cnt, 0);
        check("rst_mid_vld_cnt",  vld_cnt,  0);
        rst_sys_n = 1'b1;
        repeat (2) @(negedge clk_sys);
        run_vec(7, vecs[1]);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
